// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared FSM encodings and default sizes for the multiplier
//               job scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    localparam int unsigned c_m_default       = 8;
    localparam int unsigned c_depth_default   = 4;
    localparam int unsigned c_tag_w_default   = 4;
    localparam int unsigned c_timeout_default = 40;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = c_st_idle,
        ST_ISSUE = c_st_issue,
        ST_WAIT  = c_st_wait
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mul_op_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mul_op_fifo
// Description : Synchronous operand FIFO; head data is read combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_op_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);

    localparam int c_aw = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [c_aw:0]  r_wr_ptr;
    logic [c_aw:0]  r_rd_ptr;
    logic [W-1:0]   r_mem [DEPTH];
    logic           w_push;
    logic           w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign o_head  = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/mul_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mul_job_scheduler
// Description : Queues operand pairs, issues them one at a time to the
//               shift-add multiplier core and returns tagged results.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_job_scheduler import mul_pkg::*; #(
    parameter int M       = c_m_default,
    parameter int DEPTH   = c_depth_default,
    parameter int TAG_W   = c_tag_w_default,
    parameter int TIMEOUT = c_timeout_default
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M-1:0]     in_a,
    input  logic [M-1:0]     in_b,
    output logic             mul_start,
    output logic [M-1:0]     mul_a,
    output logic [M-1:0]     mul_b,
    input  logic             mul_done,
    input  logic [2*M-1:0]   mul_product,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2*M-1:0]   res_product,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err
);

    localparam int              c_wd_w    = $clog2(TIMEOUT);
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_full;
    logic             w_empty;
    logic [2*M-1:0]   w_head;
    logic             w_issue;
    logic             w_done;
    logic             w_timeout;
    logic             w_load;
    logic [M-1:0]     r_mul_a;
    logic [M-1:0]     r_mul_b;
    logic [TAG_W-1:0] r_tag_cnt;
    logic [TAG_W-1:0] r_job_tag;
    logic [c_wd_w-1:0] r_wd;
    logic             r_res_valid;
    logic [2*M-1:0]   r_res_product;
    logic [TAG_W-1:0] r_res_tag;
    logic             r_res_err;

    mul_op_fifo #(
        .W     (2*M),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .nrst        (nrst),
        .i_push      (in_valid && !w_full),
        .i_push_data ({in_a, in_b}),
        .i_pop       (w_issue),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (w_head)
    );

    // A result slot being drained this cycle counts as free.
    assign w_issue   = (r_state == ST_IDLE) && !w_empty && (!r_res_valid || res_ready);
    assign w_done    = (r_state == ST_WAIT) && mul_done;
    assign w_timeout = (r_state == ST_WAIT) && !mul_done && (r_wd == c_wd_last);
    assign w_load    = w_done || w_timeout;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_issue) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (w_load) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_tag_cnt     <= '0;
            r_job_tag     <= '0;
            r_wd          <= '0;
            r_res_valid   <= 1'b0;
            r_res_product <= '0;
            r_res_tag     <= '0;
            r_res_err     <= 1'b0;
        end else begin
            if (w_issue) begin
                r_mul_a   <= w_head[2*M-1:M];
                r_mul_b   <= w_head[M-1:0];
                r_job_tag <= r_tag_cnt;
            end

            if (r_state == ST_ISSUE) begin
                r_wd <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wd <= r_wd + 1'b1;
            end

            if (w_load) begin
                r_res_valid   <= 1'b1;
                r_res_product <= w_done ? mul_product : '0;
                r_res_tag     <= r_job_tag;
                r_res_err     <= !w_done;
                r_tag_cnt     <= r_tag_cnt + 1'b1;
            end else if (res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign in_ready    = !w_full;
    assign mul_start   = (r_state == ST_ISSUE);
    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign res_valid   = r_res_valid;
    assign res_product = r_res_product;
    assign res_tag     = r_res_tag;
    assign res_err     = r_res_err;

endmodule
`default_nettype wire

// File: tb/tb_mul_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_job_scheduler
// Description : Directed self-checking bench for mul_job_scheduler with a
//               behavioural shift-add core model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_job_scheduler;

    localparam int M       = 8;
    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 40;

    logic             clk = 1'b0;
    logic             nrst;
    logic             in_valid;
    logic             in_ready;
    logic [M-1:0]     in_a;
    logic [M-1:0]     in_b;
    logic             mul_start;
    logic [M-1:0]     mul_a;
    logic [M-1:0]     mul_b;
    logic             mul_done;
    logic [2*M-1:0]   mul_product;
    logic             res_valid;
    logic             res_ready;
    logic [2*M-1:0]   res_product;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_job_scheduler #(
        .M       (M),
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_done    (mul_done),
        .mul_product (mul_product),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_product (res_product),
        .res_tag     (res_tag),
        .res_err     (res_err)
    );

    // Core model: done rises core_delay cycles after the start cycle and
    // stays high for core_hold cycles.
    int         core_delay = 17;
    int         core_hold  = 1;
    bit         core_never = 1'b0;
    int         cm_cnt;
    bit         cm_busy;
    int         cm_hold_left;
    logic [M-1:0] cm_a;
    logic [M-1:0] cm_b;

    always @(negedge clk) begin
        if (!nrst) begin
            cm_busy      = 1'b0;
            cm_cnt       = 0;
            cm_hold_left = 0;
            mul_done     = 1'b0;
            mul_product  = '0;
        end else begin
            mul_done = 1'b0;
            if (cm_hold_left > 0) begin
                mul_done = 1'b1;
                cm_hold_left--;
            end
            if (cm_busy) begin
                cm_cnt--;
                if (cm_cnt == 0) begin
                    cm_busy      = 1'b0;
                    mul_done     = 1'b1;
                    mul_product  = 16'(cm_a) * 16'(cm_b);
                    cm_hold_left = core_hold - 1;
                end
            end
            if (mul_start && !core_never) begin
                cm_busy = 1'b1;
                cm_cnt  = core_delay;
                cm_a    = mul_a;
                cm_b    = mul_b;
            end
        end
    end

    typedef struct {
        logic [M-1:0]     a;
        logic [M-1:0]     b;
        logic [2*M-1:0]   p;
        logic [TAG_W-1:0] tag;
    } vec_t;

    vec_t vecs [17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_in_ready"},    32'(in_ready), 1);
        check({pfx, "_mul_start"},   32'(mul_start), 0);
        check({pfx, "_mul_a"},       32'(mul_a), 0);
        check({pfx, "_mul_b"},       32'(mul_b), 0);
        check({pfx, "_res_valid"},   32'(res_valid), 0);
        check({pfx, "_res_product"}, 32'(res_product), 0);
        check({pfx, "_res_tag"},     32'(res_tag), 0);
        check({pfx, "_res_err"},     32'(res_err), 0);
    endtask

    // Waits (bounded) for res_valid; returns cycles waited.
    task automatic wait_result(output int n);
        n = 0;
        while (!res_valid && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Single job from an idle scheduler with res_ready held high.
    task automatic run_job(input logic [M-1:0] a, input logic [M-1:0] b,
                           input logic [2*M-1:0] exp_p, input logic [TAG_W-1:0] exp_tag,
                           input logic exp_err, input int exp_lat);
        int n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
        check("start_not_early", 32'(mul_start), 0);
        tick();
        check("start_at_push_plus2", 32'(mul_start), 1);
        check("mul_a_loaded", 32'(mul_a), 32'(a));
        check("mul_b_loaded", 32'(mul_b), 32'(b));
        wait_result(n);
        check("result_latency", 32'(n), 32'(exp_lat));
        check("res_product", 32'(res_product), 32'(exp_p));
        check("res_tag", 32'(res_tag), 32'(exp_tag));
        check("res_err", 32'(res_err), 32'(exp_err));
        tick();
        check("res_valid_clears", 32'(res_valid), 0);
    endtask

    initial begin
        int n;
        int cnt;
        int got;
        bit pushed5;
        logic [M-1:0]     bl_a [6];
        logic [M-1:0]     bl_b [6];
        logic [2*M-1:0]   bl_p [6];

        vecs[0]  = '{8'd13,  8'd11,  16'd143,   4'd0};
        vecs[1]  = '{8'd255, 8'd255, 16'd65025, 4'd1};
        vecs[2]  = '{8'd0,   8'd200, 16'd0,     4'd2};
        vecs[3]  = '{8'd1,   8'd1,   16'd1,     4'd3};
        vecs[4]  = '{8'd16,  8'd16,  16'd256,   4'd4};
        vecs[5]  = '{8'd100, 8'd3,   16'd300,   4'd5};
        vecs[6]  = '{8'd200, 8'd2,   16'd400,   4'd6};
        vecs[7]  = '{8'd128, 8'd255, 16'd32640, 4'd7};
        vecs[8]  = '{8'd7,   8'd9,   16'd63,    4'd8};
        vecs[9]  = '{8'd255, 8'd1,   16'd255,   4'd9};
        vecs[10] = '{8'd12,  8'd12,  16'd144,   4'd10};
        vecs[11] = '{8'd50,  8'd50,  16'd2500,  4'd11};
        vecs[12] = '{8'd99,  8'd2,   16'd198,   4'd12};
        vecs[13] = '{8'd3,   8'd85,  16'd255,   4'd13};
        vecs[14] = '{8'd64,  8'd4,   16'd256,   4'd14};
        vecs[15] = '{8'd17,  8'd15,  16'd255,   4'd15};
        vecs[16] = '{8'd170, 8'd85,  16'd14450, 4'd0};

        bl_a = '{8'd5,  8'd20,  8'd255,  8'd9,  8'd100,   8'd33};
        bl_b = '{8'd6,  8'd10,  8'd2,    8'd9,  8'd100,   8'd3};
        bl_p = '{16'd30, 16'd200, 16'd510, 16'd81, 16'd10000, 16'd99};

        nrst      = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b1;
        tick();
        tick();
        check_reset_values("reset");
        nrst = 1'b1;
        tick();

        // Table: products, latency and tag wrap across 17 jobs.
        for (int i = 0; i < 17; i++) begin
            run_job(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].tag, 1'b0, 18);
        end

        // Watchdog: first job never completes, second job then runs normally.
        core_never = 1'b1;
        in_valid = 1'b1; in_a = 8'd7; in_b = 8'd7;
        tick();
        in_a = 8'd2; in_b = 8'd3;
        tick();
        in_valid = 1'b0;
        check("to_start", 32'(mul_start), 1);
        tick();
        core_never = 1'b0;
        wait_result(n);
        check("to_latency", 32'(n + 1), 41);
        check("to_err", 32'(res_err), 1);
        check("to_product", 32'(res_product), 0);
        check("to_tag", 32'(res_tag), 1);
        tick();
        check("to_next_issue", 32'(mul_start), 1);
        check("to_next_mul_a", 32'(mul_a), 2);
        wait_result(n);
        check("to_next_latency", 32'(n), 18);
        check("to_next_product", 32'(res_product), 6);
        check("to_next_tag", 32'(res_tag), 2);
        check("to_next_err", 32'(res_err), 0);
        tick();

        // Done arriving in the same cycle as the timeout wins.
        core_delay = 40;
        run_job(8'd12, 8'd13, 16'd156, 4'd3, 1'b0, 41);
        core_delay = 17;

        // Done held for 3 cycles yields a single result.
        core_hold = 3;
        run_job(8'd21, 8'd4, 16'd84, 4'd4, 1'b0, 18);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (res_valid || mul_start) cnt++;
            tick();
        end
        check("held_done_single_result", 32'(cnt), 0);
        core_hold = 1;

        // Backlog with the result port stalled.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a = bl_a[i];
            in_b = bl_b[i];
            tick();
        end
        in_valid = 1'b0;
        check("bl_in_ready_full", 32'(in_ready), 0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (mul_start) cnt++;
            tick();
        end
        check("bl_second_start_withheld", 32'(cnt), 0);
        check("bl_first_pending", 32'(res_valid), 1);
        check("bl_first_product", 32'(res_product), 30);

        res_ready = 1'b1;
        got = 0;
        pushed5 = 1'b0;
        for (int c = 0; c < 400 && got < 6; c++) begin
            if (res_valid) begin
                check("bl_product", 32'(res_product), 32'(bl_p[got]));
                check("bl_tag", 32'(res_tag), 32'(5 + got));
                check("bl_err", 32'(res_err), 0);
                got++;
            end
            if (in_valid) begin
                in_valid = 1'b0;
                pushed5  = 1'b1;
            end else if (!pushed5 && in_ready) begin
                in_valid = 1'b1;
                in_a = bl_a[5];
                in_b = bl_b[5];
            end
            tick();
        end
        in_valid = 1'b0;
        check("bl_drained_count", 32'(got), 6);
        repeat (3) tick();

        // Reset in WAIT with three entries queued.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a = 8'd9 + 8'(i);
            in_b = 8'd9;
            tick();
        end
        in_valid = 1'b0;
        check("rst_queue_not_full", 32'(in_ready), 1);
        repeat (6) tick();
        nrst = 1'b0;
        #1;
        check_reset_values("midrst");
        tick();
        tick();
        nrst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (res_valid || mul_start) cnt++;
        end
        check("midrst_no_activity", 32'(cnt), 0);
        run_job(8'd6, 8'd7, 16'd42, 4'd0, 1'b0, 18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_job_scheduler.md
# mul_job_scheduler

Front-end for the sequential shift-add multiplier: accepts operand pairs over a valid/ready interface and buffers them in a small FIFO. Issues one job at a time to the multiplier core via a single-cycle start pulse, holds the operands stable, captures the 2M-bit product on the core's done, and presents it with a job tag on a valid/ready result port. A watchdog flags jobs whose done never arrives.

## Interface
- M, 8: operand width in bits; product is 2M bits.
- DEPTH, 4: operand FIFO entries; power of two, ≥2.
- TAG_W, 4: job tag width.
- TIMEOUT, 40: maximum cycles in WAIT before the job is aborted; must be greater than 2M+2.
- clk  in  1  clock; all state changes on the rising edge.
- nrst  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO can accept; equals !fifo_full.
- in_a, in_b  in  M each  multiplicand and multiplier.
- mul_start  out  1  one-cycle start pulse to the core.
- mul_a, mul_b  out  M each  operands; held stable from the start cycle until the job ends.
- mul_done  in  1  core finished; sampled only in WAIT.
- mul_product  in  2M  core result; valid in the cycle mul_done=1.
- res_valid  out  1  result held.
- res_ready  in  1  consumer accepts.
- res_product  out  2M  product, or 0 on error.
- res_tag  out  TAG_W  tag of the job.
- res_err  out  1  job aborted by timeout.

## Operation
- Reset values: state=IDLE, FIFO empty, in_ready=1, mul_start=0, mul_a=mul_b=0, res_valid=0, res_product=0, res_tag=0, res_err=0, tag counter=0, watchdog=0.
- Accept: when in_valid && in_ready, {in_a,in_b} is pushed. No bypass: a pushed entry is visible to the FSM the next cycle. A push and a pop in the same cycle are legal at any occupancy except full (in_ready=0 when full, regardless of a pop).
- FSM states and transitions:
  - IDLE → ISSUE when the FIFO is non-empty and the result slot is free (!res_valid, or res_valid && res_ready this cycle). On this transition: pop the head, load mul_a/mul_b, and latch the current tag.
  - ISSUE: mul_start=1 for exactly this cycle; clear the watchdog; go to WAIT.
  - WAIT: the watchdog increments each cycle.
    - If mul_done=1: res_product←mul_product, res_tag←latched tag, res_err←0, res_valid←1, tag counter +1 (wraps modulo 2^TAG_W), go to IDLE.
    - Else if the watchdog = TIMEOUT-1: res_product←0, res_err←1, res_valid←1, tag counter +1, go to IDLE.
    - If mul_done and the timeout coincide, mul_done takes priority.
- Result slot: res_valid clears on res_valid && res_ready unless the slot is reloaded in the same cycle. Result fields are stable while res_valid=1.
- mul_done outside WAIT is ignored. A mul_done held high over several cycles is consumed only once, because the FSM leaves WAIT.
- Reset mid-operation: all state returns to reset values. The FIFO contents and the in-flight job are discarded, and no result is emitted.

## Timing
- Push at cycle t → earliest mul_start at t+2 (IDLE sees the entry at t+1).
- mul_done at cycle d → res_valid=1 at d+1.
- With the companion core, mul_done arrives 2M+1 cycles after mul_start. Zero-wait result to the next mul_start takes 2 cycles minimum.
- Throughput: one job in flight; the next issue follows the return to IDLE.
- The timeout fires at the TIMEOUT-th WAIT cycle; res_valid is high the following cycle.

## Structure
- Shared package mul_pkg: FSM state encodings (IDLE, ISSUE, WAIT as 2-bit localparams), default widths M/TAG_W, and the TIMEOUT default. The watchdog width is $clog2(TIMEOUT).
- Sub-module mul_op_fifo: synchronous FIFO, width 2M, DEPTH entries, with pointers one bit wider than the address. Outputs full, empty, and head data (not registered on read).
- The top level contains the FSM, operand/result registers, tag counter, and watchdog.

## Test plan
- Single job a=13, b=11 with a core model where done arrives 2M+1 cycles after start → one mul_start pulse at push+2, res_product=143, res_tag=0, res_err=0.
- Max operands a=255, b=255 → res_product=65025. Tag sequence over 17 jobs is 0..15, 0 (wrap).
- Hold res_ready=0 and push 6 jobs back-to-back → the second mul_start is withheld while the first result is pending. in_ready drops after 4 queued entries. Raising res_ready drains all 6 results in order with correct products.
- Core never asserts done → exactly 40 cycles in WAIT, then res_valid with res_err=1, res_product=0. The next queued job then issues normally.
- mul_done and the timeout in the same cycle → res_err=0 and the product is captured. mul_done held for 3 cycles → only one result.
- nrst low during WAIT with 3 entries queued → all outputs return to reset values, and no result appears after release.
